heap_cmd_frontend: RTL and testbench
====================================

Name: heap_cmd_frontend

Overview:
CPU-facing command front-end for the hardware heap allocator. It decodes memory-mapped writes from the core's data port and queues allocate, reallocate and free commands in a small FIFO. It issues each command, one at a time, as a request pulse to the mem_allocation block. It captures the returned address and status into registers the core reads back.

Parameters:
ADDR_WIDTH, 32, width of the MMIO address bus.
DATA_WIDTH, 32, width of MMIO data and of allocator size/address buses.
FIFO_DEPTH, 4, number of command entries; must be a power of 2, minimum 2.
TIMEOUT_CYCLES, 65535, maximum cycles to wait for allocator completion.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  reset, asynchronous, active-low.
S_strobe_i  in  1  MMIO access request, 1-cycle pulse; addr[4:0] selects the register.
S_addr_i  in  ADDR_WIDTH  MMIO byte address.
S_rw_i  in  1  1 = write, 0 = read.
S_data_i  in  DATA_WIDTH  MMIO write data.
S_done_o  out  1  MMIO access complete.
S_data_o  out  DATA_WIDTH  MMIO read data, valid while S_done_o=1.
allocate_request_o  out  1  allocate pulse to the allocator.
reallocate_request_o  out  1  reallocate pulse to the allocator.
reallocate_addr_o  out  DATA_WIDTH  old block address for reallocate.
allocate_size_o  out  DATA_WIDTH  requested size in bytes.
free_request_o  out  1  free pulse to the allocator.
free_addr_o  out  DATA_WIDTH  address to free.
allocate_addr_i  in  DATA_WIDTH  returned block address.
allocate_finish_i  in  3  completion code; any nonzero value means done.
free_finish_i  in  1  free accepted.
done_irq_o  out  1  1-cycle pulse on each command retire.

Behaviour:
- Reset (rst_i=0, asynchronous): all outputs 0; FIFO empty; all registers 0; FSM in IDLE. Reset mid-command abandons the command with no retire pulse.
- MMIO timing:
  - S_done_o pulses exactly 1 cycle after S_strobe_i.
  - Read data is sampled at the strobe cycle.
  - Unmapped offsets: reads return 0, writes are ignored.
- Register map (offset):
  - 0x00 SIZE: read/write.
  - 0x04 ADDR: read/write.
  - 0x08 CMD: write-only; reads return 0. Data[1:0] selects the op: 1 = alloc, 2 = realloc, 3 = free. A write pushes {op, SIZE, ADDR} as sampled in that cycle.
  - 0x0C RESULT: read-only; allocate_addr_i latched at the last alloc/realloc retire.
  - 0x10 STATUS: read-only.
    - [0] busy: FSM not in IDLE, or FIFO non-empty.
    - [1] fifo_full.
    - [2] fifo_empty.
    - [5:3] last finish code.
    - [6] timeout.
    - [7] overflow.
    - [8] bad_op.
    - Bits [8:6] are sticky and cleared by a read of STATUS. A set event in the same cycle as the clearing read wins.
  - 0x14 COUNT: read-only; 16-bit retired-command counter, wraps 0xFFFF -> 0.
- CMD write rules:
  - Op 0: not pushed; sets bad_op.
  - FIFO full: not pushed; sets overflow.
  - A push and an FSM pop in the same cycle are both legal; occupancy is unchanged.
- FSM states IDLE, ISSUE, WAIT, RETIRE:
  - IDLE: if the FIFO is non-empty, pop the head into the command registers -> ISSUE.
  - ISSUE: drive exactly one 1-cycle request pulse and load the timeout counter -> WAIT.
    - alloc: allocate_request_o.
    - realloc: reallocate_request_o.
    - free: free_request_o.
  - WAIT:
    - alloc/realloc finish when allocate_finish_i != 0: latch RESULT and the code -> RETIRE.
    - free finishes when free_finish_i=1: code := 3'b001 -> RETIRE.
    - Counter reaching 0 first: set timeout, RESULT := 0, code := 0 -> RETIRE.
    - A completion seen in the same cycle as expiry counts as completion.
  - RETIRE: pulse done_irq_o, increment COUNT -> IDLE.
- Allocator bus stability: allocate_size_o, reallocate_addr_o and free_addr_o hold the popped values from ISSUE until RETIRE and are 0 otherwise. Request pulses never overlap.
- Completion inputs arriving outside WAIT are ignored.
- Minimum latency: CMD write at cycle t -> request pulse at t+2 -> retire 1 cycle after the completion input.

Test Plan:
- Write SIZE=0x40, then CMD=1; allocator returns finish=3'b001 with addr 0x90000040 after 5 cycles -> exactly one allocate_request_o pulse with allocate_size_o=0x40; RESULT=0x90000040; STATUS[5:3]=1; COUNT=1; one done_irq_o pulse.
- Write ADDR=0x90000040, then CMD=3 -> free_request_o pulse with free_addr_o=0x90000040; free_finish_i after 3 cycles -> retire; RESULT unchanged.
- Push 5 commands back-to-back with FIFO_DEPTH=4 while the allocator stalls -> first 4 accepted, 5th dropped; STATUS[7]=1 on read, then 0 on the next read; the 4 commands issue in FIFO order.
- Issue an alloc and never assert completion (TIMEOUT_CYCLES=16) -> retire after 16 WAIT cycles; STATUS[6]=1; RESULT=0; the FSM then proceeds to the next command.
- Assert rst_i low during WAIT -> all outputs 0 immediately; FIFO empty and COUNT=0 after release; no done_irq_o pulse.
- CMD write with op 0, and a read of offset 0x1C -> no request issued, STATUS[8]=1; the 0x1C read returns 0 with S_done_o 1 cycle after the strobe.

Source files
------------

// File: rtl/heap_cmd_frontend.sv
// MMIO command front-end for the heap allocator: register file, command
// FIFO and a one-at-a-time issue/wait/retire sequencer.
module heap_cmd_frontend #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  S_strobe_i,
    input  logic [ADDR_WIDTH-1:0] S_addr_i,
    input  logic                  S_rw_i,
    input  logic [DATA_WIDTH-1:0] S_data_i,
    output logic                  S_done_o,
    output logic [DATA_WIDTH-1:0] S_data_o,
    output logic                  allocate_request_o,
    output logic                  reallocate_request_o,
    output logic [DATA_WIDTH-1:0] reallocate_addr_o,
    output logic [DATA_WIDTH-1:0] allocate_size_o,
    output logic                  free_request_o,
    output logic [DATA_WIDTH-1:0] free_addr_o,
    input  logic [DATA_WIDTH-1:0] allocate_addr_i,
    input  logic [2:0]            allocate_finish_i,
    input  logic                  free_finish_i,
    output logic                  done_irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [4:0] OFF_SIZE   = 5'h00;
    localparam logic [4:0] OFF_ADDR   = 5'h04;
    localparam logic [4:0] OFF_CMD    = 5'h08;
    localparam logic [4:0] OFF_RESULT = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;
    localparam logic [4:0] OFF_COUNT  = 5'h14;

    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_ALLOC   = 2'd1;
    localparam logic [1:0] OP_REALLOC = 2'd2;
    localparam logic [1:0] OP_FREE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETIRE
    } state_t;

    state_t state_q, state_d;

    logic [4:0]            off;
    logic                  wr, rd, cmd_wr;
    logic [1:0]            wr_op;
    logic                  push, pop;
    logic                  fifo_empty, fifo_full, busy;
    logic [PW:0]           wr_ptr, rd_ptr;
    logic [1:0]            q_op   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_size [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_addr [FIFO_DEPTH];

    logic [DATA_WIDTH-1:0] size_q, addr_q, result_q;
    logic [2:0]            code_q;
    logic                  tmo_q, ovf_q, bad_q;
    logic [15:0]           count_q;
    logic [1:0]            cmd_op_q;
    logic [DATA_WIDTH-1:0] cmd_size_q, cmd_addr_q;
    logic [TW-1:0]         timer_q;

    logic                  in_wait, finished, expired;
    logic                  set_tmo, set_ovf, set_bad, clr_sticky;
    logic                  active;
    logic [8:0]            status_bits;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  unused_addr;

    assign off         = S_addr_i[4:0];
    assign unused_addr = ^S_addr_i[ADDR_WIDTH-1:5];
    assign wr          = S_strobe_i & S_rw_i;
    assign rd          = S_strobe_i & ~S_rw_i;
    assign cmd_wr      = wr & (off == OFF_CMD);
    assign wr_op       = S_data_i[1:0];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign busy       = (state_q != ST_IDLE) | ~fifo_empty;

    // A full FIFO refuses the push even if the sequencer pops this cycle.
    assign push    = cmd_wr & (wr_op != OP_NONE) & ~fifo_full;
    assign pop     = (state_q == ST_IDLE) & ~fifo_empty;
    assign set_bad = cmd_wr & (wr_op == OP_NONE);
    assign set_ovf = cmd_wr & (wr_op != OP_NONE) & fifo_full;

    assign in_wait  = (state_q == ST_WAIT);
    assign finished = (cmd_op_q == OP_FREE) ? free_finish_i
                                            : (allocate_finish_i != 3'd0);
    assign expired  = (timer_q == '0);
    assign set_tmo  = in_wait & ~finished & expired;
    assign clr_sticky = rd & (off == OFF_STATUS);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_op[i]   <= '0;
                q_size[i] <= '0;
                q_addr[i] <= '0;
            end
        end else begin
            if (push) begin
                q_op[wr_ptr[PW-1:0]]   <= wr_op;
                q_size[wr_ptr[PW-1:0]] <= size_q;
                q_addr[wr_ptr[PW-1:0]] <= addr_q;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT:   if (finished || expired) state_d = ST_RETIRE;
            ST_RETIRE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cmd_op_q   <= OP_NONE;
            cmd_size_q <= '0;
            cmd_addr_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                cmd_op_q   <= q_op[rd_ptr[PW-1:0]];
                cmd_size_q <= q_size[rd_ptr[PW-1:0]];
                cmd_addr_q <= q_addr[rd_ptr[PW-1:0]];
            end
            // Loaded so that expiry lands on the last allowed WAIT cycle.
            if (state_q == ST_ISSUE) begin
                timer_q <= TW'(TIMEOUT_CYCLES - 1);
            end else if (in_wait && !expired) begin
                timer_q <= timer_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            size_q   <= '0;
            addr_q   <= '0;
            result_q <= '0;
            code_q   <= '0;
            tmo_q    <= 1'b0;
            ovf_q    <= 1'b0;
            bad_q    <= 1'b0;
            count_q  <= '0;
            S_done_o <= 1'b0;
            S_data_o <= '0;
        end else begin
            if (wr && off == OFF_SIZE) size_q <= S_data_i;
            if (wr && off == OFF_ADDR) addr_q <= S_data_i;
            if (in_wait && finished) begin
                if (cmd_op_q == OP_FREE) begin
                    code_q <= 3'b001;
                end else begin
                    result_q <= allocate_addr_i;
                    code_q   <= allocate_finish_i;
                end
            end else if (set_tmo) begin
                result_q <= '0;
                code_q   <= 3'b000;
            end
            tmo_q <= (tmo_q & ~clr_sticky) | set_tmo;
            ovf_q <= (ovf_q & ~clr_sticky) | set_ovf;
            bad_q <= (bad_q & ~clr_sticky) | set_bad;
            if (state_q == ST_RETIRE) count_q <= count_q + 16'd1;
            S_done_o <= S_strobe_i;
            S_data_o <= rdata_d;
        end
    end

    assign status_bits = {bad_q, ovf_q, tmo_q, code_q,
                          fifo_empty, fifo_full, busy};

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            unique case (1'b1)
                off == OFF_SIZE:   rdata_d = size_q;
                off == OFF_ADDR:   rdata_d = addr_q;
                off == OFF_RESULT: rdata_d = result_q;
                off == OFF_STATUS: rdata_d = DATA_WIDTH'(status_bits);
                off == OFF_COUNT:  rdata_d = DATA_WIDTH'(count_q);
                default:           rdata_d = '0;
            endcase
        end
    end

    assign active = (state_q != ST_IDLE);

    assign allocate_request_o   = (state_q == ST_ISSUE) & (cmd_op_q == OP_ALLOC);
    assign reallocate_request_o = (state_q == ST_ISSUE) & (cmd_op_q == OP_REALLOC);
    assign free_request_o       = (state_q == ST_ISSUE) & (cmd_op_q == OP_FREE);

    assign allocate_size_o =
        (active && (cmd_op_q == OP_ALLOC || cmd_op_q == OP_REALLOC)) ?
        cmd_size_q : '0;
    assign reallocate_addr_o =
        (active && cmd_op_q == OP_REALLOC) ? cmd_addr_q : '0;
    assign free_addr_o =
        (active && cmd_op_q == OP_FREE) ? cmd_addr_q : '0;

    assign done_irq_o = (state_q == ST_RETIRE);

endmodule

// File: tb/tb_heap_cmd_frontend.sv
// Bench for heap_cmd_frontend: register table, directed allocator
// handshakes and a randomized run against a queue-based model.
module tb_heap_cmd_frontend;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        S_strobe_i;
    logic [31:0] S_addr_i;
    logic        S_rw_i;
    logic [31:0] S_data_i;
    logic        S_done_o;
    logic [31:0] S_data_o;
    logic        allocate_request_o;
    logic        reallocate_request_o;
    logic [31:0] reallocate_addr_o;
    logic [31:0] allocate_size_o;
    logic        free_request_o;
    logic [31:0] free_addr_o;
    logic [31:0] allocate_addr_i;
    logic [2:0]  allocate_finish_i;
    logic        free_finish_i;
    logic        done_irq_o;

    heap_cmd_frontend #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .S_strobe_i(S_strobe_i),
        .S_addr_i(S_addr_i),
        .S_rw_i(S_rw_i),
        .S_data_i(S_data_i),
        .S_done_o(S_done_o),
        .S_data_o(S_data_o),
        .allocate_request_o(allocate_request_o),
        .reallocate_request_o(reallocate_request_o),
        .reallocate_addr_o(reallocate_addr_o),
        .allocate_size_o(allocate_size_o),
        .free_request_o(free_request_o),
        .free_addr_o(free_addr_o),
        .allocate_addr_i(allocate_addr_i),
        .allocate_finish_i(allocate_finish_i),
        .free_finish_i(free_finish_i),
        .done_irq_o(done_irq_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Pulse monitors
    int n_req = 0;
    int n_alloc = 0;
    int n_done = 0;
    bit overlap = 1'b0;

    always @(negedge clk_i) begin
        if (allocate_request_o) n_alloc <= n_alloc + 1;
        if (allocate_request_o | reallocate_request_o | free_request_o)
            n_req <= n_req + 1;
        if (32'(allocate_request_o) + 32'(reallocate_request_o) +
            32'(free_request_o) > 1)
            overlap <= 1'b1;
        if (done_irq_o) n_done <= n_done + 1;
    end

    // Reference model
    typedef struct {
        logic [1:0]  op;
        logic [31:0] size;
        logic [31:0] addr;
    } cmd_t;

    cmd_t        m_q[$];
    cmd_t        cur;
    logic [31:0] m_size, m_addr, m_res;
    logic [2:0]  m_code;
    logic [15:0] m_count;
    bit          m_to, m_ov, m_bad, m_inflight;
    int          m_total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_size = 0; m_addr = 0; m_res = 0; m_code = 0; m_count = 0;
        m_to = 0; m_ov = 0; m_bad = 0; m_inflight = 0;
        m_q.delete();
    endtask

    task automatic model_write(input logic [4:0] off, input logic [31:0] d);
        cmd_t c;
        case (off)
            5'h00: m_size = d;
            5'h04: m_addr = d;
            5'h08: begin
                if (d[1:0] == 2'd0) m_bad = 1;
                else if (m_q.size() == DEPTH) m_ov = 1;
                else begin
                    c.op = d[1:0]; c.size = m_size; c.addr = m_addr;
                    m_q.push_back(c);
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] off);
        logic [31:0] v;
        v = 0;
        case (off)
            5'h00: v = m_size;
            5'h04: v = m_addr;
            5'h0C: v = m_res;
            5'h10: begin
                v[0]   = m_inflight || (m_q.size() != 0);
                v[1]   = (m_q.size() == DEPTH);
                v[2]   = (m_q.size() == 0);
                v[5:3] = m_code;
                v[6]   = m_to;
                v[7]   = m_ov;
                v[8]   = m_bad;
                m_to = 0; m_ov = 0; m_bad = 0;
            end
            5'h14: v = {16'd0, m_count};
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_retire(input bit to, input logic [2:0] code,
                                input logic [31:0] raddr);
        m_count = m_count + 16'd1;
        m_total++;
        m_inflight = 0;
        if (to) begin
            m_to = 1; m_res = 0; m_code = 0;
        end else if (cur.op == 2'd3) begin
            m_code = 3'b001;
        end else begin
            m_res = raddr; m_code = code;
        end
    endtask

    // MMIO access: strobe one cycle, sample done/data on the next
    task automatic mmio(input bit rw, input logic [4:0] off,
                        input logic [31:0] wd, output logic [31:0] rdat);
        logic d0;
        @(negedge clk_i);
        d0 = S_done_o;
        S_strobe_i = 1'b1;
        S_rw_i = rw;
        S_addr_i = {27'($urandom), off};
        S_data_i = rw ? wd : $urandom;
        @(negedge clk_i);
        S_strobe_i = 1'b0;
        S_rw_i = 1'b0;
        rdat = S_data_o;
        chk($sformatf("mmio_done@%h", off), 32'({d0, S_done_o}), 32'd1);
        if (rw) model_write(off, wd);
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        logic [31:0] r;
        mmio(1'b1, off, d, r);
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] off,
                          output logic [31:0] r);
        logic [31:0] e;
        mmio(1'b0, off, 32'd0, r);
        e = model_read(off);
        chk(nm, r, e);
    endtask

    task automatic rd_lit(input string nm, input logic [4:0] off,
                          input logic [31:0] exp);
        logic [31:0] r, e;
        mmio(1'b0, off, 32'd0, r);
        e = model_read(off);
        chk(nm, r, exp);
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] r;
        rd_chk({tag, "_result"}, 5'h0C, r);
        rd_chk({tag, "_status"}, 5'h10, r);
        rd_chk({tag, "_count"}, 5'h14, r);
    endtask

    task automatic wait_req(input int exp_lat);
        int n;
        bit got;
        n = 0; got = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk_i);
            if (allocate_request_o | reallocate_request_o | free_request_o) begin
                got = 1; n = i;
            end
        end
        chk("req_seen", 32'(got), 32'd1);
        if (!got) return;
        chk("req_expected", 32'(m_q.size() != 0), 32'd1);
        if (m_q.size() == 0) return;
        cur = m_q.pop_front();
        m_inflight = 1;
        chk("req_kind",
            32'({allocate_request_o, reallocate_request_o, free_request_o}),
            32'(3'b100 >> (cur.op - 2'd1)));
        chk("req_size", allocate_size_o, (cur.op != 2'd3) ? cur.size : 32'd0);
        chk("req_raddr", reallocate_addr_o, (cur.op == 2'd2) ? cur.addr : 32'd0);
        chk("req_faddr", free_addr_o, (cur.op == 2'd3) ? cur.addr : 32'd0);
        if (exp_lat > 0) chk("req_latency", 32'(n), 32'(exp_lat));
    endtask

    task automatic respond(input int lat, input logic [2:0] code,
                           input logic [31:0] raddr, input bit to,
                           input int tmo_wait);
        int n;
        n = 0;
        if (to) begin
            for (int i = 1; i <= tmo_wait + 10 && n == 0; i++) begin
                @(negedge clk_i);
                if (done_irq_o) n = i;
            end
            chk("timeout_latency", 32'(n), 32'(tmo_wait));
        end else begin
            repeat (lat) @(negedge clk_i);
            if (cur.op == 2'd3) free_finish_i = 1'b1;
            else begin
                allocate_finish_i = code;
                allocate_addr_i = raddr;
            end
            @(negedge clk_i);
            free_finish_i = 1'b0;
            allocate_finish_i = 3'd0;
            allocate_addr_i = $urandom;
            chk("retire_latency", 32'(done_irq_o), 32'd1);
        end
        chk("hold_size", allocate_size_o, (cur.op != 2'd3) ? cur.size : 32'd0);
        chk("hold_faddr", free_addr_o, (cur.op == 2'd3) ? cur.addr : 32'd0);
        model_retire(to, code, raddr);
    endtask

    typedef struct {
        bit          rw;
        logic [4:0]  off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[20];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, a0;
        logic [31:0] r;
        logic [1:0] fops[5];
        logic [1:0] op;
        bit all_zero;

        S_strobe_i = 0; S_addr_i = 0; S_rw_i = 0; S_data_i = 0;
        allocate_addr_i = 0; allocate_finish_i = 0; free_finish_i = 0;
        rst_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        all_zero = ({S_done_o, S_data_o, allocate_request_o,
                     reallocate_request_o, reallocate_addr_o, allocate_size_o,
                     free_request_o, free_addr_o, done_irq_o} === '0);
        chk("reset_outputs", 32'(all_zero), 32'd1);
        rst_i = 1'b1;

        // Register map table
        tbl[0]  = '{0, 5'h00, 32'h0, 32'h0};
        tbl[1]  = '{0, 5'h04, 32'h0, 32'h0};
        tbl[2]  = '{0, 5'h08, 32'h0, 32'h0};
        tbl[3]  = '{0, 5'h0C, 32'h0, 32'h0};
        tbl[4]  = '{0, 5'h10, 32'h0, 32'h4};
        tbl[5]  = '{0, 5'h14, 32'h0, 32'h0};
        tbl[6]  = '{1, 5'h00, 32'hDEADBEEF, 32'h0};
        tbl[7]  = '{0, 5'h00, 32'h0, 32'hDEADBEEF};
        tbl[8]  = '{1, 5'h04, 32'h12345678, 32'h0};
        tbl[9]  = '{0, 5'h04, 32'h0, 32'h12345678};
        tbl[10] = '{1, 5'h0C, 32'hFFFF, 32'h0};
        tbl[11] = '{0, 5'h0C, 32'h0, 32'h0};
        tbl[12] = '{1, 5'h14, 32'h5, 32'h0};
        tbl[13] = '{0, 5'h14, 32'h0, 32'h0};
        tbl[14] = '{1, 5'h1C, 32'hAA, 32'h0};
        tbl[15] = '{0, 5'h1C, 32'h0, 32'h0};
        tbl[16] = '{0, 5'h18, 32'h0, 32'h0};
        tbl[17] = '{1, 5'h10, 32'hFFFFFFFF, 32'h0};
        tbl[18] = '{0, 5'h10, 32'h0, 32'h4};
        tbl[19] = '{0, 5'h01, 32'h0, 32'h0};
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].rw) wr(tbl[i].off, tbl[i].wd);
            else rd_lit($sformatf("vec%0d", i), tbl[i].off, tbl[i].exp);
        end

        // Alloc of 0x40, allocator answers after 5 cycles
        #1 s0 = n_done; a0 = n_alloc;
        wr(5'h00, 32'h40);
        wr(5'h08, 32'h1);
        wait_req(1);
        respond(5, 3'b001, 32'h90000040, 0, 0);
        rd_lit("alloc_result", 5'h0C, 32'h90000040);
        rd_chk("alloc_status", 5'h10, r);
        chk("alloc_code", 32'(r[5:3]), 32'd1);
        rd_lit("alloc_count", 5'h14, 32'd1);
        #1;
        chk("alloc_pulses", 32'(n_alloc - a0), 32'd1);
        chk("alloc_irq", 32'(n_done - s0), 32'd1);

        // Free of the same block
        wr(5'h04, 32'h90000040);
        wr(5'h08, 32'h3);
        wait_req(1);
        respond(3, 3'b000, 32'h0, 0, 0);
        rd_lit("free_result", 5'h0C, 32'h90000040);
        check_regs("free");

        // Completion inputs while idle are ignored
        allocate_finish_i = 3'd7; allocate_addr_i = 32'hBAD0BAD0;
        free_finish_i = 1'b1;
        repeat (3) @(negedge clk_i);
        allocate_finish_i = 3'd0; free_finish_i = 1'b0;
        rd_lit("idle_cmpl_count", 5'h14, 32'd2);
        rd_lit("idle_cmpl_result", 5'h0C, 32'h90000040);

        // Overflow: one command stalled in WAIT, five more pushed
        wr(5'h00, 32'h100);
        wr(5'h08, 32'h1);
        wait_req(1);
        fops = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd2};
        for (int i = 0; i < 5; i++) wr(5'h08, {30'($urandom), fops[i]});
        rd_lit("ovf_status1", 5'h10, 32'h8B);
        rd_lit("ovf_status2", 5'h10, 32'h0B);
        respond(0, 3'b001, 32'hA0000000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            wait_req(2);
            respond(2, 3'(k + 1), 32'hA0000010 + 32'(k), 0, 0);
        end
        check_regs("fifo");
        rd_lit("fifo_count", 5'h14, 32'd7);

        // Timeout, then the queued command still issues
        wr(5'h00, 32'h80);
        wr(5'h08, 32'h1);
        wait_req(1);
        wr(5'h08, 32'h2);
        respond(0, 3'b000, 32'h0, 1, TO + 1 - 2);
        wait_req(2);
        respond(4, 3'b010, 32'hC0000000, 0, 0);
        check_regs("after_tmo");
        wr(5'h08, 32'h1);
        wait_req(1);
        respond(0, 3'b000, 32'h0, 1, TO + 1);
        rd_lit("tmo_result", 5'h0C, 32'h0);
        rd_chk("tmo_status", 5'h10, r);
        chk("tmo_bit", 32'(r[6]), 32'd1);

        // Completion on the expiry cycle wins over timeout
        wr(5'h08, 32'h1);
        wait_req(1);
        respond(TO, 3'b101, 32'h77700000, 0, 0);
        rd_chk("edge_status", 5'h10, r);
        chk("edge_no_tmo", 32'(r[6]), 32'd0);
        rd_lit("edge_result", 5'h0C, 32'h77700000);

        // Op 0 and unmapped read
        #1 s0 = n_req;
        wr(5'h08, 32'h4);
        repeat (5) @(negedge clk_i);
        #1 chk("op0_no_req", 32'(n_req - s0), 32'd0);
        rd_lit("unmapped_1c", 5'h1C, 32'h0);
        rd_chk("op0_status", 5'h10, r);
        chk("bad_op_bit", 32'(r[8]), 32'd1);

        // Randomized commands
        for (int it = 0; it < 30; it++) begin
            op = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            wr(5'h00, $urandom);
            wr(5'h04, $urandom);
            #1 s1 = n_req;
            wr(5'h08, {30'($urandom), op});
            if (op == 2'd0) begin
                repeat (4) @(negedge clk_i);
                #1 chk("rnd_op0_no_req", 32'(n_req - s1), 32'd0);
                rd_chk("rnd_op0_status", 5'h10, r);
            end else begin
                wait_req(1);
                respond($urandom_range(1, 8), 3'($urandom_range(1, 7)),
                        $urandom, ($urandom_range(0, 5) == 0), TO + 1);
                check_regs("rnd");
            end
        end

        // Reset while waiting on the allocator
        wr(5'h00, 32'h55);
        wr(5'h08, 32'h2);
        wait_req(1);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        all_zero = ({S_done_o, S_data_o, allocate_request_o,
                     reallocate_request_o, reallocate_addr_o, allocate_size_o,
                     free_request_o, free_addr_o, done_irq_o} === '0);
        chk("midwait_reset_outputs", 32'(all_zero), 32'd1);
        s0 = n_done;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1 chk("reset_no_irq", 32'(n_done - s0), 32'd0);
        model_reset();
        rd_lit("post_rst_count", 5'h14, 32'd0);
        rd_lit("post_rst_status", 5'h10, 32'h4);
        rd_lit("post_rst_result", 5'h0C, 32'h0);
        rd_lit("post_rst_size", 5'h00, 32'h0);

        #1;
        chk("no_overlap", 32'(overlap), 32'd0);
        chk("irq_total", 32'(n_done), 32'(m_total));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
